// File: rtl/requantize_unit.sv
// requantize_unit: fetches per-layer multiplier/shift from the scale ROM at
// layer start, then streams signed accumulators through a 3-stage
// fixed-point requantize pipeline (saturating left shift, rounding doubling
// high multiply, rounding divide by power of two) into clamped activations.
module requantize_unit #(
  parameter int NUM_LAYERS  = 6,
  parameter int MULT_WIDTH  = 32,
  parameter int SHIFT_WIDTH = 6,
  parameter int ACC_WIDTH   = 32,
  parameter int OUT_WIDTH   = 8,
  localparam int IDX_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          layer_start,
  input  logic [IDX_W-1:0]              layer_idx,
  input  logic signed [OUT_WIDTH-1:0]   out_zero_point,
  output logic                          cfg_err,
  output logic                          params_ready,
  output logic                          rom_valid,
  output logic [IDX_W-1:0]              rom_layer_idx,
  input  logic signed [MULT_WIDTH-1:0]  rom_mult,
  input  logic signed [SHIFT_WIDTH-1:0] rom_shift,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [ACC_WIDTH-1:0]   in_acc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_WIDTH-1:0]   out_data
);

  localparam int STAGES = 3;
  localparam int XW     = 2 * ACC_WIDTH;          // left-shift headroom
  localparam int PW     = ACC_WIDTH + MULT_WIDTH; // full product width
  localparam int FB     = MULT_WIDTH - 1;         // fraction bits of mult
  localparam int RS_MAX = ACC_WIDTH - 1;

  localparam logic signed [ACC_WIDTH-1:0]  ACC_MAX   = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0]  ACC_MIN   = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [MULT_WIDTH-1:0] MULT_MIN  = {1'b1, {(MULT_WIDTH-1){1'b0}}};
  localparam logic signed [XW-1:0]         X_MAX     = XW'(ACC_MAX);
  localparam logic signed [XW-1:0]         X_MIN     = XW'(ACC_MIN);
  localparam logic signed [PW-1:0]         NUDGE_POS = PW'(1) <<< (FB - 1);
  localparam logic signed [PW-1:0]         NUDGE_NEG = PW'(1) - NUDGE_POS;
  localparam logic signed [PW-1:0]         TRUNC_B   = (PW'(1) <<< FB) - PW'(1);
  localparam logic signed [ACC_WIDTH:0]    O_MAX     = (ACC_WIDTH+1)'((2 ** (OUT_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH:0]    O_MIN     = (ACC_WIDTH+1)'(-(2 ** (OUT_WIDTH-1)));

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_CAPT  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]                    state_q, state_d;
  logic                          req;
  logic                          idx_ok;
  logic                          cfg_err_q;
  logic [IDX_W-1:0]              idx_q;
  logic signed [OUT_WIDTH-1:0]   zp_pend_q;
  logic signed [MULT_WIDTH-1:0]  mult_q;
  logic signed [SHIFT_WIDTH-1:0] shift_q;
  logic signed [OUT_WIDTH-1:0]   zp_q;

  logic [STAGES:1]               vld_pipe_q;
  logic                          stall;
  logic                          in_fire;

  logic signed [ACC_WIDTH-1:0]   x_q, x_d;
  logic signed [ACC_WIDTH-1:0]   y_q, y_d;
  logic signed [OUT_WIDTH-1:0]   o_q, o_d;

  int                            ls, rs;
  logic signed [XW-1:0]          acc_ext, acc_shl;
  logic signed [PW-1:0]          prod, rsum, radj, rq;
  logic [ACC_WIDTH-1:0]          mask, rem, thr;
  logic signed [ACC_WIDTH-1:0]   ysh, z;
  logic signed [ACC_WIDTH:0]     zsum;

  assign idx_ok  = (int'(layer_idx) < NUM_LAYERS);
  assign stall   = vld_pipe_q[STAGES] & ~out_ready;
  assign in_fire = in_valid & in_ready;

  assign cfg_err       = cfg_err_q;
  assign params_ready  = (state_q == S_RUN);
  assign rom_valid     = (state_q == S_FETCH);
  assign rom_layer_idx = idx_q;
  assign in_ready      = (state_q == S_RUN) & ~stall;
  assign out_valid     = vld_pipe_q[STAGES];
  assign out_data      = o_q;

  // Layer-load sequencing; a reload from RUN waits for the pipe to empty so
  // in-flight beats finish with the parameters they entered with.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    case (state_q)
      S_IDLE:  if (layer_start && idx_ok) begin state_d = S_FETCH; req = 1'b1; end
      S_FETCH: state_d = S_CAPT;
      S_CAPT:  state_d = S_RUN;
      S_RUN:   if (layer_start && idx_ok) begin state_d = S_DRAIN; req = 1'b1; end
      S_DRAIN: if (vld_pipe_q == '0) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, request latching and parameter capture from the ROM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cfg_err_q <= 1'b0;
      idx_q     <= '0;
      zp_pend_q <= '0;
      mult_q    <= '0;
      shift_q   <= '0;
      zp_q      <= '0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= layer_start & ~idx_ok;
      if (req) begin
        idx_q     <= layer_idx;
        zp_pend_q <= out_zero_point;
      end
      // zp only becomes active here, so draining beats keep the old one
      if (state_q == S_CAPT) begin
        mult_q  <= rom_mult;
        shift_q <= rom_shift;
        zp_q    <= zp_pend_q;
      end
    end
  end

  // Split the signed shift into left/right amounts; right shift capped.
  always_comb begin
    ls = 0;
    rs = 0;
    if (shift_q > 0) ls = int'(shift_q);
    if (shift_q < 0) rs = -int'(shift_q);
    if (rs > RS_MAX) rs = RS_MAX;
  end

  // S1: saturating left shift, computed wide so overflow is visible.
  always_comb begin
    acc_ext = XW'(in_acc);
    acc_shl = acc_ext <<< ls;
    if (acc_shl > X_MAX)      x_d = ACC_MAX;
    else if (acc_shl < X_MIN) x_d = ACC_MIN;
    else                      x_d = acc_shl[ACC_WIDTH-1:0];
  end

  // S2: rounding doubling high multiply; the division truncates toward zero,
  // so negative sums get a bias before the arithmetic shift.
  always_comb begin
    prod = PW'(x_q) * PW'(mult_q);
    rsum = prod + (prod[PW-1] ? NUDGE_NEG : NUDGE_POS);
    radj = rsum[PW-1] ? (rsum + TRUNC_B) : rsum;
    rq   = radj >>> FB;
    if (x_q == ACC_MIN && mult_q == MULT_MIN) y_d = ACC_MAX;
    else                                      y_d = rq[ACC_WIDTH-1:0];
  end

  // S3: rounding right shift (half away from zero), zero point, clamp.
  always_comb begin
    mask = (ACC_WIDTH'(1) << rs) - ACC_WIDTH'(1);
    rem  = y_q & mask;
    thr  = (mask >> 1) + {{(ACC_WIDTH-1){1'b0}}, y_q[ACC_WIDTH-1]};
    ysh  = y_q >>> rs;
    z    = ysh + $signed({{(ACC_WIDTH-1){1'b0}}, (rem > thr)});
    zsum = (ACC_WIDTH+1)'(z) + (ACC_WIDTH+1)'(zp_q);
    if (zsum > O_MAX)      o_d = O_MAX[OUT_WIDTH-1:0];
    else if (zsum < O_MIN) o_d = O_MIN[OUT_WIDTH-1:0];
    else                   o_d = zsum[OUT_WIDTH-1:0];
  end

  // Datapath pipe: every stage freezes together on output backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      o_q        <= '0;
    end else if (!stall) begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], in_fire};
      x_q        <= x_d;
      y_q        <= y_d;
      o_q        <= o_d;
    end
  end

endmodule

// File: tb/tb_requantize_unit.sv
// Bench for requantize_unit: ROM model, transfer monitor, and an arithmetic
// reference model (wide integer multiply/divide) feeding an expected queue.
module tb_requantize_unit;
  localparam int NL = 6, MW = 32, SW = 6, AW = 32, OW = 8, IW = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  layer_start;
  logic [IW-1:0]         layer_idx;
  logic signed [OW-1:0]  out_zero_point;
  logic                  cfg_err, params_ready, rom_valid;
  logic [IW-1:0]         rom_layer_idx;
  logic signed [MW-1:0]  rom_mult;
  logic signed [SW-1:0]  rom_shift;
  logic                  in_valid, in_ready;
  logic signed [AW-1:0]  in_acc;
  logic                  out_valid, out_ready;
  logic signed [OW-1:0]  out_data;

  int checks = 0, errors = 0;
  int tbl_m[NL];
  int tbl_s[NL];
  int cur_m, cur_s, cur_zp;
  int exp_q[$];
  int got_q[$];
  int rom_cnt = 0;

  requantize_unit #(.NUM_LAYERS(NL), .MULT_WIDTH(MW), .SHIFT_WIDTH(SW),
                    .ACC_WIDTH(AW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .reset(reset), .layer_start(layer_start), .layer_idx(layer_idx),
    .out_zero_point(out_zero_point), .cfg_err(cfg_err), .params_ready(params_ready),
    .rom_valid(rom_valid), .rom_layer_idx(rom_layer_idx), .rom_mult(rom_mult),
    .rom_shift(rom_shift), .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));

  always #5 clk = ~clk;

  // One-cycle-latency scale ROM.
  always @(posedge clk) begin
    if (rom_valid) begin
      rom_mult  <= tbl_m[int'(rom_layer_idx)];
      rom_shift <= SW'(tbl_s[int'(rom_layer_idx)]);
    end
  end

  // Reference: saturate acc*2^ls, round (p + nudge)/2^31 toward zero,
  // divide by 2^rs rounding half away from zero, add zp, clamp to int8.
  function automatic int ref_rq(int acc, int m, int s, int zp);
    longint x, p, y, a, d, q, r, zz;
    int ls, rs;
    ls = (s > 0) ? s : 0;
    rs = (s < 0) ? -s : 0;
    if (rs > 31) rs = 31;
    x = longint'(acc) * (longint'(1) << ls);
    if (x > 64'sd2147483647) x = 64'sd2147483647;
    if (x < -64'sd2147483648) x = -64'sd2147483648;
    if (x == -64'sd2147483648 && m == int'(32'h80000000)) y = 64'sd2147483647;
    else begin
      p = x * longint'(m);
      y = (p + ((p >= 0) ? 64'sd1073741824 : (64'sd1 - 64'sd1073741824))) / 64'sd2147483648;
    end
    a = (y < 0) ? -y : y;
    d = longint'(1) << rs;
    q = a / d;
    r = a % d;
    if (2 * r >= d) q = q + 1;
    zz = ((y < 0) ? -q : q) + longint'(zp);
    if (zz > 127) zz = 127;
    if (zz < -128) zz = -128;
    return int'(zz);
  endfunction

  // Record transfers one half-cycle before the edge that takes them.
  always @(negedge clk) begin
    if (!reset) begin
      if (in_valid && in_ready) exp_q.push_back(ref_rq(int'(in_acc), cur_m, cur_s, cur_zp));
      if (out_valid && out_ready) got_q.push_back(int'(out_data));
      if (rom_valid) rom_cnt++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_layer(input int idx, input int zp, output int lat);
    layer_start    = 1'b1;
    layer_idx      = IW'(idx);
    out_zero_point = OW'(zp);
    tick();
    layer_start = 1'b0;
    cur_m  = tbl_m[idx];
    cur_s  = tbl_s[idx];
    cur_zp = zp;
    lat = 1;
    while (!params_ready && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic send(input int acc);
    int n;
    bit f;
    n = 0;
    in_valid = 1'b1;
    in_acc   = acc;
    do begin
      @(negedge clk);
      f = in_ready;
      tick();
      n++;
    end while (!f && n < 50);
    in_valid = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; layer_start = 1'b0; layer_idx = '0; out_zero_point = '0;
    in_valid = 1'b0; in_acc = '0; out_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({cfg_err, params_ready, rom_valid, in_ready, out_valid} !== 5'b0 ||
        out_data !== 8'sd0 || rom_layer_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_state got ctl=%b data=%0d idx=%0d want 0",
               {cfg_err, params_ready, rom_valid, in_ready, out_valid}, out_data, rom_layer_idx);
    end
    reset = 1'b0;
    tick(); tick();
    checks++;
    if (params_ready !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got ready=%b in_ready=%b want 0 0", params_ready, in_ready);
    end
  endtask

  task automatic test_latency;
    int lat, r0;
    logic ov0, ov1, ov2;
    logic signed [OW-1:0] od;
    r0 = rom_cnt;
    load_layer(0, 0, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL fetch_latency got %0d want 3", lat); end
    checks++;
    if (rom_cnt - r0 !== 1) begin errors++; $display("FAIL rom_reads got %0d want 1", rom_cnt - r0); end
    in_valid = 1'b1; in_acc = 100;
    tick();
    in_valid = 1'b0;
    @(negedge clk); ov0 = out_valid;
    @(negedge clk); ov1 = out_valid;
    @(negedge clk); ov2 = out_valid; od = out_data;
    checks++;
    if ({ov0, ov1, ov2} !== 3'b001) begin
      errors++; $display("FAIL pipe_latency got valid seq %b want 001", {ov0, ov1, ov2});
    end
    checks++;
    if (od !== 8'sd50) begin errors++; $display("FAIL basic_half got %0d want 50", od); end
    tick();
    drain();
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_directed;
    int lay[8] = '{0, 1, 2, 2, 3, 4, 4, 0};
    int zps[8] = '{0, 0, 0, -128, 0, 0, 0, 10};
    int acc[8] = '{101, 100, 1000, -1000, int'(32'h80000000), 32'h40000000, -32'h40000000, 100};
    int ans[8] = '{51, 25, 127, -128, 127, 127, -128, 60};
    int lat;
    for (int i = 0; i < 8; i++) begin
      load_layer(lay[i], zps[i], lat);
      checks++;
      if (!params_ready) begin errors++; $display("FAIL load_timeout row=%0d lat=%0d", i, lat); end
      send(acc[i]);
      drain();
      checks++;
      if (got_q.size() !== 1 || got_q[0] !== ans[i]) begin
        errors++;
        $display("FAIL directed row=%0d got n=%0d val=%0d want %0d", i, got_q.size(),
                 (got_q.size() > 0) ? got_q[0] : 0, ans[i]);
      end
      exp_q.delete(); got_q.delete();
    end
  endtask

  task automatic test_backpressure;
    int accs[10];
    int lat, sent, c;
    bit f;
    for (int i = 0; i < 10; i++) accs[i] = int'($urandom_range(0, 20000)) - 10000;
    load_layer(0, 3, lat);
    sent = 0; c = 0;
    while ((sent < 10 || got_q.size() < 10) && c < 200) begin
      in_valid  = (sent < 10);
      in_acc    = accs[(sent < 10) ? sent : 9];
      out_ready = !(c >= 4 && c < 9);
      @(negedge clk);
      if (!out_ready && out_valid) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
      end
      f = in_valid && in_ready;
      tick();
      if (f) sent++;
      c++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got_q.size() !== 10 || exp_q.size() !== 10) begin
      errors++; $display("FAIL burst_count got %0d/%0d want 10", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < 10 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== ref_rq(accs[i], tbl_m[0], tbl_s[0], 3)) begin
        errors++;
        $display("FAIL burst_beat %0d got %0d want %0d", i, got_q[i], ref_rq(accs[i], tbl_m[0], tbl_s[0], 3));
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_cfg_err;
    int r0, lat;
    bit pr;
    r0 = rom_cnt;
    layer_start = 1'b1; layer_idx = 3'd6; out_zero_point = 8'sd7;
    tick();
    layer_start = 1'b0;
    checks++;
    if (cfg_err !== 1'b1 || rom_valid !== 1'b0 || params_ready !== 1'b1) begin
      errors++; $display("FAIL cfg_err_pulse got err=%b rv=%b rdy=%b want 1 0 1", cfg_err, rom_valid, params_ready);
    end
    tick();
    checks++;
    if (cfg_err !== 1'b0 || rom_cnt !== r0) begin
      errors++; $display("FAIL cfg_err_end got err=%b reads=%0d want 0 0", cfg_err, rom_cnt - r0);
    end
    // three in flight, then reload to layer 1 with a new zero point
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin in_acc = 400 + 37 * i; tick(); end
    in_valid = 1'b0;
    r0 = rom_cnt;
    load_layer(1, -5, lat);
    pr = params_ready;
    checks++;
    if (!pr || got_q.size() !== 3 || rom_cnt - r0 !== 1) begin
      errors++; $display("FAIL reload_drain got rdy=%b out=%0d reads=%0d want 1 3 1", pr, got_q.size(), rom_cnt - r0);
    end
    send(1234);
    drain();
    checks++;
    if (got_q.size() !== 4) begin errors++; $display("FAIL reload_count got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL reload_beat %0d got %0d want %0d", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (got_q.size() == 4 && got_q[3] !== ref_rq(1234, tbl_m[1], tbl_s[1], -5)) begin
      errors++; $display("FAIL new_params got %0d want %0d", got_q[3], ref_rq(1234, tbl_m[1], tbl_s[1], -5));
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random;
    int lat, sent, c, zp;
    bit f;
    for (int r = 0; r < 3; r++) begin
      tbl_m[5] = int'($urandom);
      tbl_s[5] = int'($urandom_range(0, 63)) - 32;
      zp = int'($urandom_range(0, 255)) - 128;
      load_layer(5, zp, lat);
      sent = 0; c = 0;
      while ((sent < 60 || got_q.size() < exp_q.size()) && c < 2000) begin
        in_valid = (sent < 60) && ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 2))
          0:       in_acc = $urandom;
          1:       in_acc = int'($urandom_range(0, 4000)) - 2000;
          default: in_acc = ($urandom_range(0, 1) != 0) ? 32'h7FFFFFFF : 32'h80000000;
        endcase
        out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        f = in_valid && in_ready;
        tick();
        if (f) sent++;
        c++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      drain();
    end
    checks++;
    if (got_q.size() !== 180 || exp_q.size() !== 180) begin
      errors++; $display("FAIL random_count got %0d/%0d want 180", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL random_beat %0d got %0d want %0d", i, got_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_flush;
    int lat;
    load_layer(0, 0, lat);
    in_valid = 1'b1; in_acc = 500;
    tick(); tick();
    reset = 1'b1; in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || params_ready !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_reset got ov=%b rdy=%b ir=%b want 0 0 0", out_valid, params_ready, in_ready);
    end
    reset = 1'b0;
    exp_q.delete(); got_q.delete();
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (got_q.size() !== 0 || params_ready !== 1'b0) begin
      errors++; $display("FAIL flush_after got beats=%0d rdy=%b want 0 0", got_q.size(), params_ready);
    end
  endtask

  initial begin
    tbl_m = '{32'h40000000, 32'h40000000, 32'h7FFFFFFF, int'(32'h80000000), 32'h40000000, 32'h40000000};
    tbl_s = '{0, -1, 0, 0, 2, 0};
    cur_m = 0; cur_s = 0; cur_zp = 0;
    test_reset();
    test_latency();
    test_directed();
    test_backpressure();
    test_cfg_err();
    test_random();
    test_reset_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "bench timeout");
  end

endmodule
